// File: rtl/spi_mem_ctrl.sv
// SPI initiator for the spi_mem slave: serialises op/addr/wdata on miso, collects read data from mosi.
// Optional watchdog on the slave handshakes when SPI_CTRL_TIMEOUT_EN is defined.
module spi_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              cs,
  output logic              miso,
  input  logic              mosi,
  input  logic              ready,
  input  logic              op_done,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(ADDR_W + DATA_W + 1);
  localparam int FIDX_W = $clog2(ADDR_W + DATA_W);
  localparam int AIDX_W = $clog2(ADDR_W);
  localparam int DIDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(ADDR_W + DATA_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_TX_WR, S_TX_ADDR, S_WAIT_RDY, S_RX, S_WAIT_DONE, S_FIN, S_ABORT
  } state_t;

  state_t                     state, state_nx;
  logic [CNT_W-1:0]           cnt;
  logic                       wr_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          din_q;
  logic [DATA_W-1:0]          rx_shift;
  logic [ADDR_W+DATA_W-1:0]   wr_frame;

  // Write frame goes out address first, then data, both LSB first.
  assign wr_frame = {din_q, addr_q};

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd;
  logic            waiting;

  assign waiting = (state == S_WAIT_RDY) || (state == S_WAIT_DONE);

  // Leaving a wait state clears the count, so each entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !waiting || state_nx != state) wd <= '0;
    else                                      wd <= wd + 1'b1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_CMD;
      S_CMD:       if (cnt == CMD_LAST) state_nx = wr_q ? S_TX_WR : S_TX_ADDR;
      S_TX_WR:     if (cnt == WR_LAST) state_nx = op_done ? S_FIN : S_WAIT_DONE;
      S_TX_ADDR:   if (cnt == ADDR_LAST) state_nx = S_WAIT_RDY;
      S_WAIT_RDY:  if (ready) state_nx = S_RX;
      S_RX:        if (ready && cnt == RX_LAST) state_nx = op_done ? S_FIN : S_WAIT_DONE;
      S_WAIT_DONE: if (op_done) state_nx = S_FIN;
      default:     state_nx = S_IDLE;
    endcase
`ifdef SPI_CTRL_TIMEOUT_EN
    if (waiting && state_nx == state && wd == WD_LAST) state_nx = S_ABORT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rx_shift <= '0;
      dout     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            wr_q   <= wr;
            addr_q <= addr;
            din_q  <= din;
          end
        end
        S_CMD, S_TX_WR, S_TX_ADDR: cnt <= (state_nx == state) ? cnt + 1'b1 : '0;
        // The first ready cycle may land in WAIT_RDY; it already carries bit 0.
        S_WAIT_RDY, S_RX: begin
          if (ready) begin
            rx_shift[cnt[DIDX_W-1:0]] <= mosi;
            cnt                       <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          cnt <= '0;
          if (!wr_q) dout <= rx_shift;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    cs   = 1'b1;
    miso = 1'b0;
    busy = (state != S_IDLE);
    done = 1'b0;
    err  = 1'b0;
    case (state)
      S_CMD: begin
        cs   = 1'b0;
        miso = wr_q;
      end
      S_TX_WR: begin
        cs   = 1'b0;
        miso = wr_frame[cnt[FIDX_W-1:0]];
      end
      S_TX_ADDR: begin
        cs   = 1'b0;
        miso = addr_q[cnt[AIDX_W-1:0]];
      end
      S_WAIT_RDY, S_RX, S_WAIT_DONE: cs = 1'b0;
      S_FIN: done = 1'b1;
`ifdef SPI_CTRL_TIMEOUT_EN
      S_ABORT: err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- SPI initiator that drives the SPI memory slave: asserts cs, serialises the op bit, address and write data onto miso, and deserialises read data from mosi while the slave holds ready high.
- Sits between the bench/host transaction side (start/wr/addr/din) and the spi_mem pins. It is the pin-level counterpart that the memory's FSM (idle/detect/store/send_addr/temp_del/send_data) expects.

Parameters:
- ADDR_W, 8, address width; serialised LSB first.
- DATA_W, 8, data width; serialised and deserialised LSB first.
- TIMEOUT_CYC, 64, watchdog limit in clk cycles; used only with SPI_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transaction request; accepted only when busy==0.
- wr  in  1  1 = write, 0 = read; sampled with start.
- addr  in  ADDR_W  target address; sampled with start.
- din  in  DATA_W  write data; sampled with start.
- cs  out  1  chip select, active low, to slave.
- miso  out  1  serial command/addr/data to slave (slave's input pin).
- mosi  in  1  serial read data from slave.
- ready  in  1  slave read-data valid; one bit per cycle while high.
- op_done  in  1  slave end-of-operation pulse.
- busy  out  1  transaction in progress.
- dout  out  DATA_W  last read data.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle abort pulse; only with SPI_CTRL_TIMEOUT_EN.

Behaviour:
- Reset values: cs=1, miso=0, busy=0, done=0, err=0, dout=0, FSM=IDLE, bit counter=0.
- A reset asserted mid-transaction forces all reset values at the next edge, including cs=1.
- Accept: at an edge with state IDLE and start=1, latch wr, addr and din; busy=1 from the next cycle. start is ignored while busy.
- FSM states and transitions:
  - IDLE -> CMD on accept.
  - CMD: 2 cycles, cs=0, miso=wr. The slave goes idle->detect on cs low, then samples the op bit in detect.
    - wr=1 -> TX_WR; wr=0 -> TX_ADDR.
  - TX_WR: 16 cycles, miso = addr[0..7] then din[0..7]; counter 0..15 (slave store). -> WAIT_DONE.
  - TX_ADDR: 8 cycles, miso = addr[0..7]; counter 0..7. -> WAIT_RDY.
  - WAIT_RDY: cs=0, miso=0; hold until ready=1.
  - RX: each cycle with ready=1, shift mosi into rx_shift[count]; counter 0..7.
    - After 8 bits -> WAIT_DONE.
    - ready dropping before 8 bits: stall, do not count.
  - WAIT_DONE: cs=0, miso=0 until op_done=1 -> FIN. If op_done is already seen in the same cycle as the last bit, go directly to FIN.
  - FIN: 1 cycle. cs=1, done=1, busy=0 from the next cycle. On reads, dout<=rx_shift this cycle; dout holds until the next read completes. -> IDLE.
- cs stays low continuously from CMD through WAIT_DONE; no gaps.
- miso=0 whenever cs=1.
- Write cycle count, start accept to done: 1+2+16+N_wait+1.
- Read cycle count, start accept to done: 1+2+8+N_rdy+8+N_wait+1.
- start=1 in the FIN cycle is ignored. It can be accepted in the following IDLE cycle.
- ready=1 outside WAIT_RDY/RX is ignored.
- op_done outside WAIT_DONE is ignored.

Optional Feature:
- SPI_CTRL_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_RDY and WAIT_DONE, cleared on each state entry.
  - On reaching TIMEOUT_CYC: cs=1, err=1 for one cycle, done=0, dout unchanged, -> IDLE.
  - The counter is TIMEOUT_CYC-sized, $clog2(TIMEOUT_CYC+1) bits.
- Undefined: no watchdog, waits indefinitely, err tied to 0.

Test Plan:
- Reset -> cs=1, miso=0, busy=0, done=0, dout=0. Hold rst=1 for 3 cycles mid-write -> cs=1 on the next edge, FSM=IDLE.
- start, wr=1, addr=0x5A, din=0xC3 -> cs low 2+16 cycles. miso: 1,1, then 0,1,0,1,1,0,1,0, then 1,1,0,0,0,0,1,1. Slave op_done -> done pulse, cs=1.
- Write 0x3C to addr 0x11, then read addr 0x11 -> miso sequence 0,0,1,0,0,0,1,0,0,0. Slave ready with 8 bits -> dout=0x3C, single done pulse.
- Read where ready deasserts for 2 cycles after bit 3 -> still exactly 8 bits captured, correct dout, no extra done.
- start pulsed while busy -> ignored: no second cs low, latched addr/din unchanged.
- SPI_CTRL_TIMEOUT_EN, TIMEOUT_CYC=64, ready never asserted -> err=1 for one cycle, done=0, cs=1 at timeout, next transaction proceeds normally.
